// File: rtl/epu_alu_arbiter.sv
// Owner-lock arbiter sharing one iterative field multiplier and the fe_add/fe_sub units
// among NUM_CLIENTS point-arithmetic engines, with round-robin grant and drain-on-release.
module epu_alu_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int W           = 320,
    parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CLIENTS-1:0]   cl_req,
    output logic [NUM_CLIENTS-1:0]   cl_gnt,
    input  logic [NUM_CLIENTS*W-1:0] cl_mul_op_a,
    input  logic [NUM_CLIENTS*W-1:0] cl_mul_op_b,
    input  logic [NUM_CLIENTS-1:0]   cl_mul_valid,
    output logic [NUM_CLIENTS-1:0]   cl_mul_done,
    input  logic [NUM_CLIENTS*W-1:0] cl_add_op_a,
    input  logic [NUM_CLIENTS*W-1:0] cl_add_op_b,
    input  logic [NUM_CLIENTS*W-1:0] cl_sub_op_a,
    input  logic [NUM_CLIENTS*W-1:0] cl_sub_op_b,
    output logic [W-1:0]             mul_op_a,
    output logic [W-1:0]             mul_op_b,
    output logic                     mul_valid,
    input  logic                     mul_done,
    output logic [W-1:0]             add_op_a,
    output logic [W-1:0]             add_op_b,
    output logic [W-1:0]             sub_op_a,
    output logic [W-1:0]             sub_op_b,
    output logic [IDX_W-1:0]         owner_idx,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    logic [NUM_CLIENTS-1:0] gnt_r;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic                   inflight_r;
    logic                   busy_r;
    logic                   err_r;
    // A multiply abandoned by reset may still complete; its done is dropped silently.
    logic                   abandon_r;

    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [NUM_CLIENTS-1:0] pick_onehot_s;
    logic [NUM_CLIENTS-1:0] own_mask_s;
    logic [IDX_W-1:0]       next_ptr_s;
    logic                   owner_valid_s;
    logic                   owner_req_s;
    logic                   mul_fwd_s;
    logic                   err_set_s;

    // Round-robin pick: first requester at or after rr_ptr, wrapping around.
    always_comb begin : pick_proc
        int cand_v;
        cand_v       = 0;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            cand_v = (int'(rr_ptr_r) + k) % NUM_CLIENTS;
            if (!pick_valid_s && cl_req[cand_v]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = IDX_W'(cand_v);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
        pick_onehot_s             = '0;
        pick_onehot_s[pick_idx_s] = pick_valid_s;
    end

    // Owner decode, pointer successor and protocol-error detection.
    always_comb begin
        own_mask_s          = '0;
        own_mask_s[owner_r] = (state_r == ST_OWN);
        if (int'(owner_r) == NUM_CLIENTS - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_r + 1'b1;
        end
        owner_req_s   = cl_req[owner_r];
        owner_valid_s = cl_mul_valid[owner_r] & (state_r == ST_OWN);
        mul_fwd_s     = owner_valid_s & owner_req_s & ~inflight_r;
        err_set_s     = (|(cl_mul_valid & ~own_mask_s))
                      | (owner_valid_s & (inflight_r | ~owner_req_s))
                      | (mul_done & ~inflight_r & ~abandon_r & (state_r != ST_DRAIN));
    end

    // Operand mux: owner's operands while owning, zero otherwise.
    always_comb begin
        if (state_r == ST_OWN) begin
            mul_op_a = cl_mul_op_a[int'(owner_r)*W +: W];
            mul_op_b = cl_mul_op_b[int'(owner_r)*W +: W];
            add_op_a = cl_add_op_a[int'(owner_r)*W +: W];
            add_op_b = cl_add_op_b[int'(owner_r)*W +: W];
            sub_op_a = cl_sub_op_a[int'(owner_r)*W +: W];
            sub_op_b = cl_sub_op_b[int'(owner_r)*W +: W];
        end else begin
            mul_op_a = '0;
            mul_op_b = '0;
            add_op_a = '0;
            add_op_b = '0;
            sub_op_a = '0;
            sub_op_b = '0;
        end
    end

    assign mul_valid   = mul_fwd_s;
    assign cl_mul_done = own_mask_s & {NUM_CLIENTS{mul_done}};
    assign cl_gnt      = gnt_r;
    assign owner_idx   = owner_r;
    assign busy        = busy_r;
    assign err         = err_r;

    // Ownership FSM, in-flight tracking and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            inflight_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            abandon_r  <= 1'b1;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (mul_fwd_s || mul_done) begin
                abandon_r <= 1'b0;
            end
            // A new op cannot be forwarded in the cycle a done arrives, so set never races clear.
            if (mul_fwd_s) begin
                inflight_r <= 1'b1;
            end else if (mul_done) begin
                inflight_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r   <= pick_onehot_s;
                        owner_r <= pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!owner_req_s) begin
                        gnt_r    <= '0;
                        rr_ptr_r <= next_ptr_s;
                        if (inflight_r && !mul_done) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mul_done) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epu_alu_arbiter.sv
// Directed bench for epu_alu_arbiter: a 2-client instance for protocol scenarios and a
// 4-client instance for round-robin order and operand routing.
module tb_epu_alu_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 2-client instance
    logic [1:0]     req2, gnt2, mv2, md2;
    logic [2*W-1:0] mul_a2, mul_b2, add_a2, add_b2, sub_a2, sub_b2;
    logic [W-1:0]   mul_op_a2, mul_op_b2, add_op_a2, add_op_b2, sub_op_a2, sub_op_b2;
    logic           mul_valid2, mul_done2, busy2, err2;
    logic [0:0]     owner2;

    // 4-client instance
    logic [3:0]     req4, gnt4, mv4, md4;
    logic [4*W-1:0] mul_a4, mul_b4, add_a4, add_b4, sub_a4, sub_b4;
    logic [W-1:0]   mul_op_a4, mul_op_b4, add_op_a4, add_op_b4, sub_op_a4, sub_op_b4;
    logic           mul_valid4, mul_done4, busy4, err4;
    logic [1:0]     owner4;

    epu_alu_arbiter #(.NUM_CLIENTS(2), .W(W)) u_dut2 (
        .clk(clk), .rst(rst), .cl_req(req2), .cl_gnt(gnt2),
        .cl_mul_op_a(mul_a2), .cl_mul_op_b(mul_b2), .cl_mul_valid(mv2), .cl_mul_done(md2),
        .cl_add_op_a(add_a2), .cl_add_op_b(add_b2), .cl_sub_op_a(sub_a2), .cl_sub_op_b(sub_b2),
        .mul_op_a(mul_op_a2), .mul_op_b(mul_op_b2), .mul_valid(mul_valid2), .mul_done(mul_done2),
        .add_op_a(add_op_a2), .add_op_b(add_op_b2), .sub_op_a(sub_op_a2), .sub_op_b(sub_op_b2),
        .owner_idx(owner2), .busy(busy2), .err(err2)
    );

    epu_alu_arbiter #(.NUM_CLIENTS(4), .W(W)) u_dut4 (
        .clk(clk), .rst(rst), .cl_req(req4), .cl_gnt(gnt4),
        .cl_mul_op_a(mul_a4), .cl_mul_op_b(mul_b4), .cl_mul_valid(mv4), .cl_mul_done(md4),
        .cl_add_op_a(add_a4), .cl_add_op_b(add_b4), .cl_sub_op_a(sub_a4), .cl_sub_op_b(sub_b4),
        .mul_op_a(mul_op_a4), .mul_op_b(mul_op_b4), .mul_valid(mul_valid4), .mul_done(mul_done4),
        .add_op_a(add_op_a4), .add_op_b(add_op_b4), .sub_op_a(sub_op_a4), .sub_op_b(sub_op_b4),
        .owner_idx(owner4), .busy(busy4), .err(err4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req2 = 2'b00; mv2 = 2'b00; mul_done2 = 1'b0;
        req4 = 4'b0000; mv4 = 4'b0000; mul_done4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err2); end
        checks++; if (owner2 !== 1'b0) begin errors++; $display("FAIL rst_owner: got %0d want 0", owner2); end
        checks++; if (mul_valid2 !== 1'b0) begin errors++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid2); end
        checks++; if (add_op_a2 !== 32'h0) begin errors++; $display("FAIL rst_add_op: got %h want 0", add_op_a2); end
    endtask

    task automatic test_single_mul();
        req2 = 2'b01;
        tick();
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL t1_gnt: got %b want 01", gnt2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy2); end
        mv2 = 2'b01;
        #1;
        checks++; if (mul_valid2 !== 1'b1) begin errors++; $display("FAIL t1_mul_valid: got %b want 1", mul_valid2); end
        checks++; if (mul_op_a2 !== 32'h1000_0000) begin errors++; $display("FAIL t1_mul_op_a: got %h want 10000000", mul_op_a2); end
        checks++; if (mul_op_b2 !== 32'h2000_0000) begin errors++; $display("FAIL t1_mul_op_b: got %h want 20000000", mul_op_b2); end
        tick();
        mv2 = 2'b00;
        repeat (29) tick();
        mul_done2 = 1'b1;
        #1;
        checks++; if (md2 !== 2'b01) begin errors++; $display("FAIL t1_cl_mul_done: got %b want 01", md2); end
        tick();
        mul_done2 = 1'b0;
        #1;
        checks++; if (md2 !== 2'b00) begin errors++; $display("FAIL t1_done_clear: got %b want 00", md2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", err2); end
        req2 = 2'b00;
        tick();
        checks++; if (gnt2 !== 2'b00 || busy2 !== 1'b0) begin errors++; $display("FAIL t1_release: got gnt=%b busy=%b want 00/0", gnt2, busy2); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req2 = 2'b11;
        tick();
        checks++; if (gnt2 !== 2'b01 || owner2 !== 1'b0) begin errors++; $display("FAIL t2_first: got gnt=%b owner=%0d want 01/0", gnt2, owner2); end
        req2 = 2'b10;
        tick();
        checks++; if (gnt2 !== 2'b00 || busy2 !== 1'b0) begin errors++; $display("FAIL t2_gap: got gnt=%b busy=%b want 00/0", gnt2, busy2); end
        tick();
        checks++; if (gnt2 !== 2'b10 || owner2 !== 1'b1) begin errors++; $display("FAIL t2_second: got gnt=%b owner=%0d want 10/1", gnt2, owner2); end
        checks++; if (mul_op_b2 !== 32'h2000_0001) begin errors++; $display("FAIL t2_mux: got %h want 20000001", mul_op_b2); end
        req2 = 2'b00;
        tick();
        req2 = 2'b11;
        tick();
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL t2_wrap: got %b want 01", gnt2); end
        req2 = 2'b10;
        tick();
        req2 = 2'b11;
        tick();
        checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL t2_rr_fair: got %b want 10", gnt2); end
        req2 = 2'b00;
        tick();
    endtask

    task automatic test_drain();
        req2 = 2'b01;
        tick();
        mv2 = 2'b01;
        tick();
        mv2 = 2'b00;
        req2 = 2'b00;
        tick();
        checks++; if (gnt2 !== 2'b00 || busy2 !== 1'b1) begin errors++; $display("FAIL t3_drain: got gnt=%b busy=%b want 00/1", gnt2, busy2); end
        tick();
        tick();
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL t3_drain_hold: got %b want 1", busy2); end
        mul_done2 = 1'b1;
        #1;
        checks++; if (md2 !== 2'b00) begin errors++; $display("FAIL t3_done_dropped: got %b want 00", md2); end
        tick();
        mul_done2 = 1'b0;
        checks++; if (busy2 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL t3_idle: got busy=%b err=%b want 0/0", busy2, err2); end
    endtask

    task automatic test_nonowner_err();
        req2 = 2'b01;
        tick();
        mv2 = 2'b10;
        #1;
        checks++; if (mul_valid2 !== 1'b0) begin errors++; $display("FAIL t4_blocked: got %b want 0", mul_valid2); end
        tick();
        mv2 = 2'b00;
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL t4_err: got %b want 1", err2); end
        req2 = 2'b00;
        repeat (3) tick();
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL t4_sticky: got %b want 1", err2); end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL t5_err_cleared: got %b want 0", err2); end
        req2 = 2'b10;
        tick();
        mv2 = 2'b10;
        tick();
        mv2 = 2'b00;
        rst = 1'b1;
        req2 = 2'b00;
        tick();
        rst = 1'b0;
        checks++; if (gnt2 !== 2'b00 || busy2 !== 1'b0 || owner2 !== 1'b0) begin errors++; $display("FAIL t5_outputs: got gnt=%b busy=%b owner=%0d want 00/0/0", gnt2, busy2, owner2); end
        mul_done2 = 1'b1;
        #1;
        checks++; if (md2 !== 2'b00) begin errors++; $display("FAIL t5_stray_routed: got %b want 00", md2); end
        tick();
        mul_done2 = 1'b0;
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL t5_stray_err: got %b want 0", err2); end
        mul_done2 = 1'b1;
        tick();
        mul_done2 = 1'b0;
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL t5_second_stray: got %b want 1", err2); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req2 = 2'b01;
        tick();
        mv2 = 2'b01;
        tick();
        mv2 = 2'b00;
        tick();
        mul_done2 = 1'b1;
        req2 = 2'b00;
        #1;
        checks++; if (md2 !== 2'b01) begin errors++; $display("FAIL ts_drop_done: got %b want 01", md2); end
        tick();
        mul_done2 = 1'b0;
        checks++; if (busy2 !== 1'b0 || gnt2 !== 2'b00 || err2 !== 1'b0) begin errors++; $display("FAIL ts_no_drain: got busy=%b gnt=%b err=%b want 0/00/0", busy2, gnt2, err2); end
        req2 = 2'b01;
        tick();
        mv2 = 2'b01;
        tick();
        mv2 = 2'b00;
        tick();
        mul_done2 = 1'b1;
        mv2 = 2'b01;
        #1;
        checks++; if (mul_valid2 !== 1'b0) begin errors++; $display("FAIL ts_race_fwd: got %b want 0", mul_valid2); end
        tick();
        mul_done2 = 1'b0;
        mv2 = 2'b00;
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL ts_race_err: got %b want 1", err2); end
        req2 = 2'b00;
        tick();
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ts_release: got %b want 0", busy2); end
    endtask

    task automatic test_four_clients();
        int order [5];
        int exp;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req4 = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            exp = order[n];
            checks++; if (gnt4 !== 4'(1 << exp) || int'(owner4) != exp) begin errors++; $display("FAIL t6_grant%0d: got gnt=%b owner=%0d want owner %0d", n, gnt4, owner4, exp); end
            checks++; if (add_op_a4 !== 32'hA000_0000 + 32'(exp) || sub_op_b4 !== 32'hD000_0000 + 32'(exp)) begin errors++; $display("FAIL t6_ops%0d: got add_a=%h sub_b=%h want client %0d", n, add_op_a4, sub_op_b4, exp); end
            repeat (4) tick();
            req4[exp] = 1'b0;
            tick();
            checks++; if (gnt4 !== 4'b0000 || add_op_a4 !== 32'h0 || sub_op_b4 !== 32'h0) begin errors++; $display("FAIL t6_idle%0d: got gnt=%b add_a=%h sub_b=%h want 0", n, gnt4, add_op_a4, sub_op_b4); end
            req4[exp] = 1'b1;
            tick();
        end
        req4 = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1; req2 = 2'b00; mv2 = 2'b00; mul_done2 = 1'b0;
        req4 = 4'b0000; mv4 = 4'b0000; mul_done4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mul_a2[i*W +: W] = 32'h1000_0000 + 32'(i);
            mul_b2[i*W +: W] = 32'h2000_0000 + 32'(i);
            add_a2[i*W +: W] = 32'h3000_0000 + 32'(i);
            add_b2[i*W +: W] = 32'h4000_0000 + 32'(i);
            sub_a2[i*W +: W] = 32'h5000_0000 + 32'(i);
            sub_b2[i*W +: W] = 32'h6000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            mul_a4[i*W +: W] = 32'h8000_0000 + 32'(i);
            mul_b4[i*W +: W] = 32'h9000_0000 + 32'(i);
            add_a4[i*W +: W] = 32'hA000_0000 + 32'(i);
            add_b4[i*W +: W] = 32'hB000_0000 + 32'(i);
            sub_a4[i*W +: W] = 32'hC000_0000 + 32'(i);
            sub_b4[i*W +: W] = 32'hD000_0000 + 32'(i);
        end
        test_reset();
        test_single_mul();
        test_round_robin();
        test_drain();
        test_nonowner_err();
        test_reset_mid_mul();
        test_simultaneous();
        test_four_clients();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
